// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with busy/cancel handshake to the pipeline controller.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops (7..10) are enabled by defining MDU_MADD_EN.
module mul_div_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_pend;
    logic [31:0]   r_hi, r_lo;

    logic          w_is_mul, w_is_div, w_is_acc, w_accept, w_launch, w_commit;
    logic          w_sdiv;
    logic [63:0]   w_prod_s, w_prod_u, w_div_res, w_result;
    logic [31:0]   w_ua, w_ub, w_den, w_uq, w_ur, w_dq, w_dr;

    always_comb begin
        w_is_mul = (op == 4'd1) || (op == 4'd2);
        w_is_div = (op == 4'd3) || (op == 4'd4);
`ifdef MDU_MADD_EN
        w_is_acc = (op >= 4'd7) && (op <= 4'd10);
`else
        w_is_acc = 1'b0;
`endif
        w_accept = (r_state == S_IDLE) && start && !cancel;
        w_launch = w_accept && (w_is_mul || w_is_div || w_is_acc);
    end

    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes, so 0x80000000 / -1 wraps to 0x80000000 without special-casing.
    always_comb begin
        w_sdiv    = (op == 4'd3);
        w_ua      = (w_sdiv && A[31]) ? -A : A;
        w_ub      = (w_sdiv && B[31]) ? -B : B;
        w_den     = (w_ub == '0) ? 32'd1 : w_ub;
        w_uq      = w_ua / w_den;
        w_ur      = w_ua % w_den;
        w_dq      = (w_sdiv && (A[31] ^ B[31])) ? -w_uq : w_uq;
        w_dr      = (w_sdiv && A[31]) ? -w_ur : w_ur;
        w_div_res = (B == '0) ? {A, 32'hFFFF_FFFF} : {w_dr, w_dq};
    end

    always_comb begin
        w_result = '0;
        case (op)
            4'd1:       w_result = w_prod_s;
            4'd2:       w_result = w_prod_u;
            4'd3, 4'd4: w_result = w_div_res;
`ifdef MDU_MADD_EN
            4'd7:       w_result = {r_hi, r_lo} + w_prod_s;
            4'd8:       w_result = {r_hi, r_lo} + w_prod_u;
            4'd9:       w_result = {r_hi, r_lo} - w_prod_s;
            4'd10:      w_result = {r_hi, r_lo} - w_prod_u;
`endif
            default:    w_result = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: if (w_launch) w_state_nxt = S_RUN;
            S_RUN: begin
                if (cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_pend <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            if (w_launch) begin
                r_pend <= w_result;
                r_cnt  <= w_is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
            end else if (r_state == S_RUN) begin
                if (cancel) begin
                    r_pend <= '0;
                    r_cnt  <= '0;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
            if (w_commit) {r_hi, r_lo} <= r_pend;
            if (w_accept && (op == 4'd5)) r_hi <= A;
            if (w_accept && (op == 4'd6)) r_lo <= A;
        end
    end

    assign busy = (r_state == S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO and busy length, a monitor pops on each output event.
module tb_mul_div_unit;

    localparam int unsigned MUL_N = 5;
    localparam int unsigned DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset, start, cancel, busy;
    logic [3:0]  op;
    logic [31:0] A, B, hi, lo;

    always #5 clk = ~clk;

    mul_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0, errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          req_cnt = 0, seen_cnt = 0;
    int          run_len = 0;
    logic        prev_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] o);
`ifdef MDU_MADD_EN
        return (o >= 4'd1) && (o <= 4'd10);
`else
        return (o >= 4'd1) && (o <= 4'd6);
`endif
    endfunction

    function automatic int latency(input logic [3:0] o);
        if (o == 4'd3 || o == 4'd4) return DIV_N;
        if (o == 4'd5 || o == 4'd6) return 0;
        return MUL_N;
    endfunction

    function automatic logic [63:0] ref_op(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] base);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = a;
        ub  = b;
        res = base;
        case (o)
            4'd1: res = sa * sb;
            4'd2: res = ua * ub;
            4'd3: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
            4'd5: res = {a, base[31:0]};
            4'd6: res = {base[63:32], a};
`ifdef MDU_MADD_EN
            4'd7:  res = base + 64'(sa * sb);
            4'd8:  res = base + 64'(ua * ub);
            4'd9:  res = base - 64'(sa * sb);
            4'd10: res = base - 64'(ua * ub);
`endif
            default: res = base;
        endcase
        return res;
    endfunction

    task automatic pop_check(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got output event with hi=%h lo=%h expected none", name, hi, lo);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_hi"}, hi, e.hi);
            chk({name, "_lo"}, lo, e.lo);
            chk({name, "_busy_len"}, 32'(run_len), 32'(e.len));
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (busy === 1'b1) begin
            run_len++;
        end else begin
            if (prev_busy) pop_check("busy_end");
            if (seen_cnt != req_cnt) begin
                seen_cnt++;
                pop_check("idle_op");
            end
            run_len = 0;
        end
        prev_busy = (busy === 1'b1);
    end

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 200) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", i);
        end
    endtask

    task automatic push_exp(input int len);
        exp_t e;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.len = len;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
        bit accepted;
        int len;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b; cancel = c;
        accepted = !c && is_legal(o);
        len      = accepted ? latency(o) : 0;
        if (accepted) {m_hi, m_lo} = ref_op(o, a, b, {m_hi, m_lo});
        push_exp(len);
        @(negedge clk);
        start = 1'b0; op = '0; cancel = 1'b0;
        if (len == 0) req_cnt++;
        else          wait_idle();
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] sp [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        if ($urandom_range(0, 2) == 0) return sp[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        issue(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(4'd4, 32'd7, 32'd0, 1'b0);

        // DIVU cancelled in its 4th busy cycle: no commit, busy high 4 cycles
        @(negedge clk);
        start = 1'b1; op = 4'd4; A = 32'd100; B = 32'd7;
        push_exp(4);
        @(negedge clk);
        start = 1'b0; op = '0;
        repeat (3) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        wait_idle();

        issue(4'd5, 32'h5555, 32'd0, 1'b1);
        issue(4'd6, 32'h1234, 32'd0, 1'b0);

        // MTHI issued while MULT is busy is dropped
        @(negedge clk);
        start = 1'b1; op = 4'd1; A = 32'd12345; B = 32'hFFFF_0000;
        {m_hi, m_lo} = ref_op(4'd1, 32'd12345, 32'hFFFF_0000, {m_hi, m_lo});
        push_exp(MUL_N);
        @(negedge clk);
        start = 1'b0; op = '0;
        @(negedge clk);
        start = 1'b1; op = 4'd5; A = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; op = '0;
        wait_idle();

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(4'd3, 32'hFFFF_FFF0, 32'd0, 1'b0);
        issue(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
        issue(4'd5, 32'd0, 32'd0, 1'b0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue(4'd8, 32'd1, 32'd1, 1'b0);
        issue(4'd9, 32'd3, 32'hFFFF_FFFF, 1'b0);
        issue(4'd0, 32'd9, 32'd9, 1'b0);
        issue(4'd13, 32'd9, 32'd9, 1'b0);

        // Reset in the 2nd busy cycle aborts the op and clears HI/LO
        @(negedge clk);
        start = 1'b1; op = 4'd2; A = 32'd77; B = 32'd88;
        m_hi = '0; m_lo = '0;
        push_exp(2);
        @(negedge clk);
        start = 1'b0; op = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            issue(4'($urandom_range(0, 15)), rand_operand(), rand_operand(),
                  ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
